chacha_state_builder: RTL and testbench



---
 rtl/chacha_state_builder_pkg.sv | 22 ++
 rtl/chacha_state_builder.sv | 146 ++++++++++++++
 tb/tb_chacha_state_builder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/chacha_state_builder_pkg.sv
// Shared constants, state word indices and FSM encoding for the ChaCha state builder.
package chacha_pkg;

  localparam logic [31:0] CHACHA_CONST0 = 32'h6170_7865;
  localparam logic [31:0] CHACHA_CONST1 = 32'h3320_646e;
  localparam logic [31:0] CHACHA_CONST2 = 32'h7962_2d32;
  localparam logic [31:0] CHACHA_CONST3 = 32'h6b20_6574;
  localparam logic [127:0] CHACHA_CONST = {CHACHA_CONST3, CHACHA_CONST2,
                                           CHACHA_CONST1, CHACHA_CONST0};

  localparam int KEY_BASE   = 4;
  localparam int CTR_IDX    = 12;
  localparam int NONCE_BASE = 13;
  localparam int FILL_WORDS = 11;
  localparam int KEY_WORDS  = CTR_IDX - KEY_BASE;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/chacha_state_builder.sv
// Assembles the 512-bit ChaCha initial state from TRNG words and serves it block by block.
// Optional macro CHACHA_STATE_BUILDER_REPCHECK_EN enables the TRNG repetition check.
module chacha_state_builder
  import chacha_pkg::*;
#(
  parameter logic [31:0] COUNTER_INIT = 32'd1,
  parameter int unsigned MAX_BLOCKS   = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  trng_data,
  input  logic         trng_ready,
  output logic         trng_request,
  input  logic         rekey,
  output logic         state_valid,
  input  logic         state_ready,
  output logic [511:0] state_out,
  output logic [7:0]   key_epoch,
  output logic         health_err
);

  localparam logic [31:0] MAX_BLOCKS_W = 32'(MAX_BLOCKS);
  localparam logic [3:0]  LAST_IDX     = 4'(FILL_WORDS - 1);

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [31:0] ctr_q, ctr_d;
  logic [31:0] blocks_q, blocks_d;
  logic [7:0]  epoch_q, epoch_d;
  logic        req_q, req_d;
  logic        herr_q, herr_d;
  // Capture order: key words 0..7, then nonce words 8..10.
  logic [31:0] fill_q [FILL_WORDS];

  logic capture, rep_hit, accept, fill_done, handshake, budget_done;

  assign capture   = (state_q == FILL) && req_q && trng_ready;
  assign accept    = capture && !rekey && !rep_hit;
  assign fill_done = accept && (idx_q == LAST_IDX);
  assign handshake = (state_q == READY) && state_ready;
  assign budget_done = handshake &&
                       ((blocks_q + 32'd1 == MAX_BLOCKS_W) || (ctr_q == 32'hFFFF_FFFF));

`ifdef CHACHA_STATE_BUILDER_REPCHECK_EN
  logic [31:0] prev_q;

  assign rep_hit = (idx_q != 4'd0) && (trng_data == prev_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      prev_q <= '0;
    else if (accept) prev_q <= trng_data;
  end

  always_comb begin
    herr_d = herr_q;
    if (rekey)                  herr_d = 1'b0;
    else if (capture && rep_hit) herr_d = 1'b1;
  end
`else
  assign rep_hit = 1'b0;
  assign herr_d  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_done)             state_d = READY;
      READY:   if (rekey || budget_done)  state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    state_valid  = (state_q == READY);
    trng_request = req_q;
    key_epoch    = epoch_q;
    health_err   = herr_q;
  end

  always_comb begin
    idx_d    = idx_q;
    ctr_d    = ctr_q;
    blocks_d = blocks_q;
    epoch_d  = epoch_q;
    req_d    = (state_d == FILL);
    if (state_q == FILL) begin
      if (rekey) begin
        idx_d = 4'd0;
      end else if (fill_done) begin
        idx_d    = 4'd0;
        ctr_d    = COUNTER_INIT;
        blocks_d = '0;
        epoch_d  = epoch_q + 8'd1;
      end else if (accept) begin
        idx_d = idx_q + 4'd1;
      end
    end else if (handshake) begin
      ctr_d    = ctr_q + 32'd1;
      blocks_d = blocks_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      ctr_q    <= COUNTER_INIT;
      blocks_q <= '0;
      epoch_q  <= '0;
      req_q    <= 1'b0;
      herr_q   <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      ctr_q    <= ctr_d;
      blocks_q <= blocks_d;
      epoch_q  <= epoch_d;
      req_q    <= req_d;
      herr_q   <= herr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FILL_WORDS; i++) fill_q[i] <= '0;
    end else if (accept) begin
      fill_q[idx_q] <= trng_data;
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_word
    if (gi < KEY_BASE) begin : g_const
      assign state_out[32*gi +: 32] = CHACHA_CONST[32*gi +: 32];
    end else if (gi < CTR_IDX) begin : g_key
      assign state_out[32*gi +: 32] = fill_q[gi - KEY_BASE];
    end else if (gi == CTR_IDX) begin : g_ctr
      assign state_out[32*gi +: 32] = ctr_q;
    end else begin : g_nonce
      assign state_out[32*gi +: 32] = fill_q[gi - NONCE_BASE + KEY_WORDS];
    end
  end

endmodule

// File: tb/tb_chacha_state_builder.sv
// Directed, table-driven bench for chacha_state_builder (built with MAX_BLOCKS=4).
module tb_chacha_state_builder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  trng_data = '0;
  logic         trng_ready = 1'b0;
  logic         trng_request;
  logic         rekey = 1'b0;
  logic         state_valid;
  logic         state_ready = 1'b0;
  logic [511:0] state_out;
  logic [7:0]   key_epoch;
  logic         health_err;

  int checks = 0;
  int passed = 0;
  logic [31:0] feed [$];
  logic [31:0] w [11];

  typedef struct {
    logic        sready;
    logic        tready;
    logic        exp_valid;
    logic        exp_req;
    logic [31:0] exp_ctr;
    bit          chk_key;
  } vec_t;

  always #5 clk = ~clk;

  chacha_state_builder #(.COUNTER_INIT(32'd1), .MAX_BLOCKS(4)) dut (
    .clk(clk), .rst_n(rst_n), .trng_data(trng_data), .trng_ready(trng_ready),
    .trng_request(trng_request), .rekey(rekey), .state_valid(state_valid),
    .state_ready(state_ready), .state_out(state_out), .key_epoch(key_epoch),
    .health_err(health_err)
  );

  function automatic logic [511:0] mk_state(input logic [31:0] fw [11], input logic [31:0] ctr);
    logic [511:0] s;
    s[31:0]   = 32'h61707865;
    s[63:32]  = 32'h3320646e;
    s[95:64]  = 32'h79622d32;
    s[127:96] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[32*(4+i) +: 32] = fw[i];
    s[32*12 +: 32] = ctr;
    for (int i = 0; i < 3; i++) s[32*(13+i) +: 32] = fw[8+i];
    return s;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed words from `feed` until state_valid rises; counts clock edges taken.
  task automatic run_fill(input bit toggle, output int cycles);
    int p;
    logic took;
    p = 0;
    cycles = 0;
    while (!state_valid && cycles < 100) begin
      trng_data  = (p < feed.size()) ? feed[p] : 32'hFFFF0000;
      trng_ready = toggle ? (cycles % 2 == 0) : 1'b1;
      took = trng_request && trng_ready;
      step();
      if (took) p++;
      cycles++;
    end
    trng_ready = 1'b0;
  endtask

  initial begin
    vec_t vecs [5];
    int   cyc, cnt, guard;
    logic took;

    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd3, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd5, 1'b0};

    // Reset state
    trng_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 11; i++) w[i] = '0;
    chk("rst_request", trng_request, 0);
    chk("rst_valid", state_valid, 0);
    chk("rst_epoch", key_epoch, 0);
    chk("rst_health", health_err, 0);
    chk("rst_state", state_out, mk_state(w, 32'd1));

    // First fill at full TRNG rate
    @(negedge clk);
    rst_n = 1'b1;
    feed.delete();
    for (int i = 0; i < 11; i++) begin
      feed.push_back(32'h100 + 32'(i));
      w[i] = 32'h100 + 32'(i);
    end
    run_fill(1'b0, cyc);
    chk("fill1_valid_cycle", cyc, 12);
    chk("fill1_state", state_out, mk_state(w, 32'd1));
    chk("fill1_epoch", key_epoch, 1);
    chk("fill1_request", trng_request, 0);

    // Handshakes up to the block budget; trng_ready while not requesting is ignored
    for (int i = 0; i < 5; i++) begin
      state_ready = vecs[i].sready;
      trng_ready  = vecs[i].tready;
      trng_data   = 32'hDEADBEEF;
      step();
      chk($sformatf("hs%0d_valid", i), state_valid, vecs[i].exp_valid);
      chk($sformatf("hs%0d_req", i), trng_request, vecs[i].exp_req);
      chk($sformatf("hs%0d_ctr", i), state_out[32*12 +: 32], vecs[i].exp_ctr);
      if (vecs[i].chk_key)
        chk($sformatf("hs%0d_state", i), state_out, mk_state(w, vecs[i].exp_ctr));
    end
    state_ready = 1'b0;
    trng_ready  = 1'b0;

    // Second fill: rekey after 5 captured words, toggling trng_ready
    cnt = 0;
    guard = 0;
    while (cnt < 5 && guard < 50) begin
      trng_data  = 32'h200 + 32'(cnt);
      trng_ready = (guard % 2 == 0);
      took = trng_request && trng_ready;
      step();
      if (took) cnt++;
      guard++;
    end
    chk("fill2_partial_words", cnt, 5);
    rekey      = 1'b1;
    trng_ready = 1'b1;
    trng_data  = 32'h2FF;
    step();
    rekey      = 1'b0;
    trng_ready = 1'b0;
    feed.delete();
    for (int i = 0; i < 11; i++) begin
      feed.push_back(32'h300 + 32'(i));
      w[i] = 32'h300 + 32'(i);
    end
    run_fill(1'b1, cyc);
    chk("fill2_valid", state_valid, 1);
    chk("fill2_state", state_out, mk_state(w, 32'd1));
    chk("fill2_epoch", key_epoch, 2);

    // Rekey coinciding with a handshake
    state_ready = 1'b1;
    rekey       = 1'b1;
    step();
    state_ready = 1'b0;
    rekey       = 1'b0;
    chk("rk_hs_ctr", state_out[32*12 +: 32], 32'd2);
    chk("rk_hs_valid", state_valid, 0);
    chk("rk_hs_req", trng_request, 1);
    chk("rk_hs_epoch", key_epoch, 2);

    // Third fill with a repeated TRNG word
    feed.delete();
    feed.push_back(32'hAAAA5555);
    feed.push_back(32'hAAAA5555);
    for (int i = 0; i < 10; i++) feed.push_back(32'h400 + 32'(i));
    run_fill(1'b0, cyc);
`ifdef CHACHA_STATE_BUILDER_REPCHECK_EN
    w[0] = 32'hAAAA5555;
    for (int i = 1; i < 11; i++) w[i] = 32'h400 + 32'(i - 1);
    chk("rep_cycles", cyc, 12);
    chk("rep_health", health_err, 1);
`else
    w[0] = 32'hAAAA5555;
    w[1] = 32'hAAAA5555;
    for (int i = 2; i < 11; i++) w[i] = 32'h400 + 32'(i - 2);
    chk("rep_cycles", cyc, 11);
    chk("rep_health", health_err, 0);
`endif
    chk("rep_state", state_out, mk_state(w, 32'd1));
    chk("rep_epoch", key_epoch, 3);

    // Rekey in READY without a handshake clears health_err and refills
    rekey = 1'b1;
    step();
    rekey = 1'b0;
    chk("rk_valid", state_valid, 0);
    chk("rk_req", trng_request, 1);
    chk("rk_health", health_err, 0);
    chk("rk_ctr", state_out[32*12 +: 32], 32'd1);

    // Asynchronous reset mid-fill
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 11; i++) w[i] = '0;
    chk("arst_req", trng_request, 0);
    chk("arst_epoch", key_epoch, 0);
    chk("arst_state", state_out, mk_state(w, 32'd1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
